hub_align_stage: RTL and testbench

Pipelined operand-alignment front end of the FPHUB adder. It accepts two HUB floating-point operands and an add/sub command, compares exponents and magnitudes, and swaps the operands so the larger one is always "big". It then produces the extended mantissas, the clamped shift amount and the effective operation. Its outputs drive the mantissa shifter (small mantissa, logical right shift) and the downstream add/normalize stages, through a valid/ready handshake with a throughput of 1 operation per cycle.

---
 rtl/hub_add_pkg.sv | 25 ++
 rtl/hub_align_stage_if.sv | 31 +++
 rtl/hub_unpack.sv | 13 +
 rtl/hub_align_stage.sv | 115 +++++++++++
 tb/tb_hub_align_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hub_add_pkg.sv
// rtl/hub_add_pkg.sv - shared widths, HUB operand layout and mantissa unpack helper
package hub_add_pkg;

    localparam int M = 23;
    localparam int E = 8;
    localparam int extra_bits_mantissa = 7;
    localparam int W = M + extra_bits_mantissa;

    typedef struct packed {
        logic         sign;
        logic [E-1:0] exp;
        logic [M-1:0] mant;
    } hub_operand_t;

    // {hidden 1, mantissa, ILSB 1, zero padding}; a zero exponent encodes the value zero
    function automatic logic [W-1:0] unpack_mant(input hub_operand_t op);
        logic [W-1:0] ext;
        ext = W'({1'b1, op.mant, 1'b1}) << (extra_bits_mantissa - 2);
        if (op.exp == '0) begin
            ext = '0;
        end
        return ext;
    endfunction

endpackage

// File: rtl/hub_align_stage_if.sv
// rtl/hub_align_stage_if.sv - operand input and aligned output handshake bundle
interface hub_align_stage_if;
    import hub_add_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [E+M:0] x_in;
    logic [E+M:0] y_in;
    logic         sub_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] big_mant;
    logic [W-1:0] small_mant;
    logic [E:0]   shift_amount;
    logic [E-1:0] big_exp;
    logic         result_sign;
    logic         eff_sub;

    modport master (
        output in_valid, x_in, y_in, sub_op, out_ready,
        input  in_ready, out_valid, big_mant, small_mant, shift_amount,
               big_exp, result_sign, eff_sub
    );

    modport slave (
        input  in_valid, x_in, y_in, sub_op, out_ready,
        output in_ready, out_valid, big_mant, small_mant, shift_amount,
               big_exp, result_sign, eff_sub
    );

endinterface

// File: rtl/hub_unpack.sv
// rtl/hub_unpack.sv - combinational operand to extended mantissa and zero flag
module hub_unpack
    import hub_add_pkg::*;
(
    input  hub_operand_t  op,
    output logic [W-1:0]  ext_mant,
    output logic          is_zero
);

    assign ext_mant = unpack_mant(op);
    assign is_zero  = (op.exp == '0);

endmodule

// File: rtl/hub_align_stage.sv
// rtl/hub_align_stage.sv - two-stage exponent compare, swap and shift-amount front end
module hub_align_stage
    import hub_add_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    hub_align_stage_if.slave  bus
);

    hub_operand_t x_op, y_op;
    logic         s1_en, s2_en;
    logic         s1_valid, s2_valid;
    hub_operand_t s1_x, s1_y;
    logic         s1_sub;
    logic [E:0]   s1_diff;
    logic         s1_x_ge;
    logic         x_ge_d;
    logic [E:0]   diff_d;

    assign x_op = bus.x_in;
    assign y_op = bus.y_in;

    // in_ready follows out_ready combinationally so a full pipe still streams at full rate
    assign s2_en        = !s2_valid || bus.out_ready;
    assign s1_en        = !s1_valid || s2_en;
    assign bus.in_ready = s1_en;

    assign x_ge_d = (x_op.exp > y_op.exp) ||
                    ((x_op.exp == y_op.exp) && (x_op.mant >= y_op.mant));
    assign diff_d = {1'b0, x_op.exp} - {1'b0, y_op.exp};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_sub   <= 1'b0;
            s1_diff  <= '0;
            s1_x_ge  <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_x    <= x_op;
                s1_y    <= y_op;
                s1_sub  <= bus.sub_op;
                s1_diff <= diff_d;
                s1_x_ge <= x_ge_d;
            end
        end
    end

    logic [W-1:0] x_ext, y_ext;
    logic         x_zero, y_zero;
    logic [E:0]   abs_diff;
    logic [W-1:0] big_mant_d, small_mant_d;
    logic [E:0]   shift_d;
    logic [E-1:0] big_exp_d;
    logic         result_sign_d, eff_sub_d;

    hub_unpack u_unpack_x (.op(s1_x), .ext_mant(x_ext), .is_zero(x_zero));
    hub_unpack u_unpack_y (.op(s1_y), .ext_mant(y_ext), .is_zero(y_zero));

    always_comb begin
        abs_diff      = s1_diff[E] ? (~s1_diff + (E+1)'(1)) : s1_diff;
        shift_d       = (abs_diff > (E+1)'(W)) ? (E+1)'(W) : abs_diff;
        eff_sub_d     = s1_x.sign ^ s1_y.sign ^ s1_sub;
        big_mant_d    = x_zero ? '0 : x_ext;
        small_mant_d  = y_zero ? '0 : y_ext;
        big_exp_d     = s1_x.exp;
        result_sign_d = s1_x.sign;
        // equal magnitudes keep X as big so big - small never goes negative
        if (!s1_x_ge) begin
            big_mant_d    = y_zero ? '0 : y_ext;
            small_mant_d  = x_zero ? '0 : x_ext;
            big_exp_d     = s1_y.exp;
            result_sign_d = s1_y.sign ^ s1_sub;
        end
    end

    logic [W-1:0] big_mant_q, small_mant_q;
    logic [E:0]   shift_q;
    logic [E-1:0] big_exp_q;
    logic         result_sign_q, eff_sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid      <= 1'b0;
            big_mant_q    <= '0;
            small_mant_q  <= '0;
            shift_q       <= '0;
            big_exp_q     <= '0;
            result_sign_q <= 1'b0;
            eff_sub_q     <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                big_mant_q    <= big_mant_d;
                small_mant_q  <= small_mant_d;
                shift_q       <= shift_d;
                big_exp_q     <= big_exp_d;
                result_sign_q <= result_sign_d;
                eff_sub_q     <= eff_sub_d;
            end
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.big_mant     = big_mant_q;
    assign bus.small_mant   = small_mant_q;
    assign bus.shift_amount = shift_q;
    assign bus.big_exp      = big_exp_q;
    assign bus.result_sign  = result_sign_q;
    assign bus.eff_sub      = eff_sub_q;

endmodule

// File: tb/tb_hub_align_stage.sv
// tb/tb_hub_align_stage.sv - scoreboard bench with reference model for hub_align_stage
module tb_hub_align_stage;
    import hub_add_pkg::*;

    typedef struct packed {
        logic [W-1:0] bm;
        logic [W-1:0] sm;
        logic [E:0]   sh;
        logic [E-1:0] be;
        logic         rs;
        logic         es;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hub_align_stage_if bus ();
    hub_align_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    res_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    logic rdy_random = 1'b0;
    logic rdy_force = 1'b1;
    logic saw_block = 1'b0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [E+M:0] op(input logic s, input int e, input int m);
        return {s, E'(e), M'(m)};
    endfunction

    function automatic res_t mkres(input logic [W-1:0] bm, input logic [W-1:0] sm, input int sh,
                                   input int be, input logic rs, input logic es);
        res_t r;
        r.bm = bm; r.sm = sm; r.sh = (E+1)'(sh); r.be = E'(be); r.rs = rs; r.es = es;
        return r;
    endfunction

    function automatic logic [W-1:0] ext_of(input int e, input longint m);
        longint v;
        if (e == 0) return '0;
        v = ((longint'(1) << (M + 1)) + (m << 1) + 1) << (extra_bits_mantissa - 2);
        return v[W-1:0];
    endfunction

    function automatic res_t model(input logic [E+M:0] x, input logic [E+M:0] y, input logic sub);
        int     ex, ey, d;
        longint mx, my;
        logic   sx, sy, xbig;
        ex = int'(x[E+M-1:M]); ey = int'(y[E+M-1:M]);
        mx = longint'(x[M-1:0]); my = longint'(y[M-1:0]);
        sx = x[E+M]; sy = y[E+M];
        xbig = (ex * (longint'(1) << M) + mx) >= (ey * (longint'(1) << M) + my);
        d = (ex > ey) ? ex - ey : ey - ex;
        if (d > W) d = W;
        if (xbig) return mkres(ext_of(ex, mx), ext_of(ey, my), d, ex, sx, sx ^ sy ^ sub);
        return mkres(ext_of(ey, my), ext_of(ex, mx), d, ey, sy ^ sub, sx ^ sy ^ sub);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            bus.out_ready = rdy_random ? ($urandom_range(0, 9) < 7) : rdy_force;
        end
    end

    initial begin
        res_t prev, cur, e;
        logic prev_stall;
        prev = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            cur = {bus.big_mant, bus.small_mant, bus.shift_amount, bus.big_exp, bus.result_sign, bus.eff_sub};
            if (prev_stall) check("stable_while_stalled", {bus.out_valid, cur}, {1'b1, prev});
            if (!bus.in_ready) saw_block = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_valid", bus.out_valid, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("out", cur, e);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev = cur;
        end
    end

    task automatic send_op(input logic [E+M:0] x, input logic [E+M:0] y, input logic s, input res_t e);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.x_in = x; bus.y_in = y; bus.sub_op = s;
        while (1) begin
            #1;
            if (bus.in_ready) begin
                sb_q.push_back(e);
                @(posedge clk);
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", bus.in_ready, 1'b1);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_rand();
        logic [E+M:0] x, y;
        logic s;
        int   r;
        x = {$urandom_range(0, 1), E'($urandom_range(1, 254)), M'($urandom)};
        y = {$urandom_range(0, 1), E'($urandom_range(1, 254)), M'($urandom)};
        r = $urandom_range(0, 9);
        if (r == 0) x[E+M-1:M] = '0;
        if (r == 1) y[E+M-1:M] = '0;
        if (r == 2 || r == 3) y[E+M-1:M] = x[E+M-1:M];
        if (r == 3) y[M-1:0] = x[M-1:0];
        if (r == 4) y[E+M-1:M] = x[E+M-1:M] + E'($urandom_range(0, 40));
        s = 1'($urandom_range(0, 1));
        send_op(x, y, s, model(x, y, s));
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", sb_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.sub_op = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_big_mant", bus.big_mant, '0);
        check("reset_shift", bus.shift_amount, '0);
        @(negedge clk);
        rst_n = 1'b1;

        send_op(op(0, 127, 0), op(0, 126, 0), 1'b0, mkres(30'h20000020, 30'h20000020, 1, 127, 0, 0));
        send_op(op(1, 100, 0), op(1, 140, 0), 1'b1, mkres(30'h20000020, 30'h20000020, 30, 140, 0, 1));
        send_op(op(0, 127, 1), op(0, 127, 2), 1'b1, mkres(30'h200000A0, 30'h20000060, 0, 127, 1, 1));
        send_op(op(1, 127, 5), op(0, 127, 5), 1'b0, mkres(30'h20000160, 30'h20000160, 0, 127, 1, 1));
        send_op(op(0, 0, 'h12345), op(0, 127, 0), 1'b0, mkres(30'h20000020, 30'h0, 30, 127, 0, 0));
        idle();
        drain();

        rdy_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();
        @(posedge clk);
        rdy_random = 1'b0;
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);

        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand();
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                rdy_force = 1'b0;
                repeat (4) @(posedge clk);
                rdy_force = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped", saw_block, 1'b1);

        @(posedge clk);
        rdy_force = 1'b0;
        send_rand();
        send_rand();
        idle();
        @(negedge clk);
        #3;
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_out_valid", bus.out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 1'b0);
        check("async_rst_in_ready", bus.in_ready, 1'b1);
        sb_q.delete();
        @(posedge clk);
        rdy_force = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            check("post_rst_quiet", bus.out_valid, 1'b0);
        end
        send_op(op(0, 130, 'h400000), op(1, 128, 'h7fffff), 1'b0,
                model(op(0, 130, 'h400000), op(1, 128, 'h7fffff), 1'b0));
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
